// File: rtl/mult_share_arbiter.sv
// Round-robin arbiter sharing one sequential shift-add multiplier between R requesters.
// Optional MULT_ARB_ZERO_BYPASS_EN: zero operands skip the multiplier and answer 0 directly.
module mult_share_arbiter #(
    parameter int N   = 4,
    parameter int R   = 3,
    parameter int IDW = $clog2(R)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [R-1:0]      req_valid,
    output logic [R-1:0]      req_ready,
    input  logic [R*N-1:0]    req_a,
    input  logic [R*N-1:0]    req_b,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [IDW-1:0]    resp_id,
    output logic [2*N-1:0]    resp_product,
    output logic              mul_start,
    output logic [N-1:0]      mul_multiplicand,
    output logic [N-1:0]      mul_multiplier,
    input  logic              mul_ready,
    input  logic [2*N-1:0]    mul_product,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t         state_reg, state_next;
    logic [IDW-1:0] rr_ptr_reg, rr_ptr_next;
    logic [IDW-1:0] id_reg;
    logic [N-1:0]   opa_reg, opb_reg;
    logic [2*N-1:0] product_reg;

    logic [N-1:0]   a_arr [R];
    logic [N-1:0]   b_arr [R];
    logic [N-1:0]   a_sel, b_sel;
    logic [IDW-1:0] grant_idx;
    logic           grant_found;
    logic           grant;
    logic           zero_op;

    generate
        for (genvar gi = 0; gi < R; gi++) begin : g_unpack
            assign a_arr[gi] = req_a[gi*N +: N];
            assign b_arr[gi] = req_b[gi*N +: N];
        end
    endgenerate

    // Search order rr_ptr, rr_ptr+1, ... mod R; the outer loop sets priority.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        a_sel       = '0;
        b_sel       = '0;
        for (int k = 0; k < R; k++) begin
            for (int i = 0; i < R; i++) begin
                if (!grant_found && req_valid[i] && (i == (int'(rr_ptr_reg) + k) % R)) begin
                    grant_found = 1'b1;
                    grant_idx   = IDW'(i);
                    a_sel       = a_arr[i];
                    b_sel       = b_arr[i];
                end
            end
        end
    end

    assign rr_ptr_next = (grant_idx == IDW'(R-1)) ? '0 : grant_idx + 1'b1;

`ifdef MULT_ARB_ZERO_BYPASS_EN
    assign zero_op = (a_sel == '0) || (b_sel == '0);
`else
    assign zero_op = 1'b0;
`endif

    always_comb begin
        state_next = state_reg;
        req_ready  = '0;
        mul_start  = 1'b0;
        grant      = 1'b0;
        case (state_reg)
            IDLE: begin
                if (mul_ready && grant_found) begin
                    grant      = 1'b1;
                    req_ready  = {{(R-1){1'b0}}, 1'b1} << grant_idx;
                    state_next = zero_op ? RESP : ISSUE;
                end
            end
            ISSUE: begin
                mul_start  = 1'b1;
                state_next = WAIT;
            end
            WAIT: begin
                if (mul_ready) state_next = RESP;
            end
            RESP: begin
                if (resp_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg   <= IDLE;
            rr_ptr_reg  <= '0;
            id_reg      <= '0;
            opa_reg     <= '0;
            opb_reg     <= '0;
            product_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (grant) begin
                opa_reg    <= a_sel;
                opb_reg    <= b_sel;
                id_reg     <= grant_idx;
                rr_ptr_reg <= rr_ptr_next;
                if (zero_op) product_reg <= '0;
            end
            // WAIT never sees mul_ready on its first cycle, so this is the finished product.
            if (state_reg == WAIT && mul_ready) product_reg <= mul_product;
        end
    end

    assign resp_valid       = (state_reg == RESP);
    assign busy             = (state_reg != IDLE);
    assign resp_id          = id_reg;
    assign resp_product     = product_reg;
    assign mul_multiplicand = opa_reg;
    assign mul_multiplier   = opb_reg;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Bench for mult_share_arbiter: behavioural multiplier, timeline model checked every cycle, directed tests.
module tb_mult_share_arbiter;

    localparam int N   = 4;
    localparam int R   = 3;
    localparam int IDW = $clog2(R);

    logic              clock;
    logic              reset;
    logic [R-1:0]      req_valid;
    logic [R-1:0]      req_ready;
    logic [R*N-1:0]    req_a;
    logic [R*N-1:0]    req_b;
    logic              resp_valid;
    logic              resp_ready;
    logic [IDW-1:0]    resp_id;
    logic [2*N-1:0]    resp_product;
    logic              mul_start;
    logic [N-1:0]      mul_multiplicand;
    logic [N-1:0]      mul_multiplier;
    logic              mul_ready;
    logic [2*N-1:0]    mul_product;
    logic              busy;

    mult_share_arbiter #(.N(N), .R(R)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_id(resp_id), .resp_product(resp_product),
        .mul_start(mul_start), .mul_multiplicand(mul_multiplicand),
        .mul_multiplier(mul_multiplier), .mul_ready(mul_ready),
        .mul_product(mul_product), .busy(busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int checks_total  = 0;
    int checks_passed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks_total++;
        if (act === exp) checks_passed++;
        else $display("FAIL %s cycle=%0d actual=%0d required=%0d", name, cyc, act, exp);
    endtask

    // Shared multiplier: ready low for exactly N cycles after start, product appears when done.
    int             mcnt;
    logic [2*N-1:0] mpend;
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            mul_ready   <= 1'b1;
            mul_product <= '0;
            mcnt        <= 0;
            mpend       <= '0;
        end else if (mul_ready) begin
            if (mul_start) begin
                mul_ready   <= 1'b0;
                mcnt        <= N;
                mpend       <= {{N{1'b0}}, mul_multiplicand} * {{N{1'b0}}, mul_multiplier};
                mul_product <= '0;
            end
        end else begin
            if (mcnt == 1) begin
                mul_ready   <= 1'b1;
                mul_product <= mpend;
            end
            mcnt <= mcnt - 1;
        end
    end

    // Timeline model: one job in flight, outputs derived from its age since the grant cycle.
    bit         m_busy, m_bypass, e_start, e_rv;
    int         m_t, m_rr, m_owner, m_prod, m_resp_prod, m_opa, m_opb, age, g, idx;
    logic [R-1:0] e_rr;
    initial begin
        m_busy = 0; m_bypass = 0; m_t = 0; m_rr = 0; m_owner = 0;
        m_prod = 0; m_resp_prod = 0; m_opa = 0; m_opb = 0;
    end

    always @(negedge clock) begin
        if (cyc > 0) begin
            if (reset) begin
                m_busy = 0; m_rr = 0; m_owner = 0; m_resp_prod = 0; m_opa = 0; m_opb = 0;
            end
            e_rr = '0; e_start = 0; e_rv = 0; g = -1;
            if (!reset && m_busy) begin
                age = cyc - m_t;
                if (m_bypass) e_rv = (age >= 1);
                else begin
                    e_start = (age == 1);
                    e_rv    = (age >= N + 3);
                end
                if (e_rv) m_resp_prod = m_prod;
            end else if (!reset && mul_ready) begin
                for (int k = 0; k < R; k++) begin
                    idx = (m_rr + k) % R;
                    if (g < 0 && req_valid[idx]) g = idx;
                end
                if (g >= 0) e_rr[g] = 1'b1;
            end
            chk("req_ready", 32'(req_ready), 32'(e_rr));
            chk("resp_valid", 32'(resp_valid), 32'(e_rv));
            chk("mul_start", 32'(mul_start), 32'(e_start));
            chk("busy", 32'(busy), 32'(m_busy));
            chk("resp_id", 32'(resp_id), 32'(m_owner));
            chk("resp_product", 32'(resp_product), 32'(m_resp_prod));
            chk("mul_multiplicand", 32'(mul_multiplicand), 32'(m_opa));
            chk("mul_multiplier", 32'(mul_multiplier), 32'(m_opb));
            if (!reset) begin
                if (m_busy && e_rv && resp_ready) begin
                    $display("resp id=%0d product=%0d cycle=%0d", m_owner, m_prod, cyc);
                    m_busy = 0;
                end else if (!m_busy && g >= 0) begin
                    m_busy  = 1;
                    m_t     = cyc;
                    m_owner = g;
                    m_opa   = int'(req_a[g*N +: N]);
                    m_opb   = int'(req_b[g*N +: N]);
                    m_prod  = m_opa * m_opb;
                    m_rr    = (g + 1) % R;
`ifdef MULT_ARB_ZERO_BYPASS_EN
                    m_bypass = (m_opa == 0) || (m_opb == 0);
`else
                    m_bypass = 0;
`endif
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_req(input int i, input int a, input int b);
        req_a[i*N +: N] = N'(a);
        req_b[i*N +: N] = N'(b);
    endtask

    function automatic int oh2i(input logic [R-1:0] v);
        int r;
        r = -1;
        for (int i = R - 1; i >= 0; i--) if (v[i]) r = i;
        return r;
    endfunction

    // Returns one cycle after the grant cycle t.
    task automatic wait_grant(output logic [R-1:0] got, output int t);
        bit done;
        done = 0; got = '0; t = -1;
        for (int k = 0; k < 40 && !done; k++) begin
            #1;
            if (req_ready != '0) begin
                got = req_ready; t = cyc; done = 1;
            end else begin
                @(posedge clock); #1;
            end
        end
        if (!done) chk("grant_timeout", 32'd0, 32'd1);
        tick();
    endtask

    task automatic wait_resp(output int r);
        bit done;
        done = 0; r = -1;
        for (int k = 0; k < 40 && !done; k++) begin
            if (resp_valid) begin
                r = cyc; done = 1;
            end else tick();
        end
        if (!done) chk("resp_timeout", 32'd0, 32'd1);
    endtask

    logic [R-1:0] got;
    int t, r, ng, nr;
    int g_id [4];
    int g_cyc [4];
    int r_id [3];
    int r_prod [3];

    initial begin
        reset = 1'b1; req_valid = '0; req_a = '0; req_b = '0; resp_ready = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        reset = 1'b0;

        // Single request
        set_req(0, 13, 11); req_valid = 3'b001;
        wait_grant(got, t);
        req_valid = '0;
        chk("t1_grant", 32'(got), 32'b001);
        chk("t1_start", 32'(mul_start), 32'd1);
        tick();
        chk("t1_start_pulse", 32'(mul_start), 32'd0);
        wait_resp(r);
        chk("t1_latency", 32'(r - t), 32'd7);
        chk("t1_id", 32'(resp_id), 32'd0);
        chk("t1_product", 32'(resp_product), 32'd143);
        tick();

        // All three requesting continuously
        reset = 1'b1; tick(); reset = 1'b0;
        set_req(0, 1, 2); set_req(1, 15, 15); set_req(2, 7, 3);
        req_valid = 3'b111;
        ng = 0; nr = 0;
        for (int k = 0; k < 80 && ng < 4; k++) begin
            #1;
            if (req_ready != '0) begin g_id[ng] = oh2i(req_ready); g_cyc[ng] = cyc; ng++; end
            if (resp_valid && nr < 3) begin r_id[nr] = int'(resp_id); r_prod[nr] = int'(resp_product); nr++; end
            @(posedge clock); #1;
        end
        req_valid = '0;
        chk("t2_grants", 32'(ng), 32'd4);
        chk("t2_resps", 32'(nr), 32'd3);
        chk("t2_g0", 32'(g_id[0]), 32'd0);
        chk("t2_g1", 32'(g_id[1]), 32'd1);
        chk("t2_g2", 32'(g_id[2]), 32'd2);
        chk("t2_g3", 32'(g_id[3]), 32'd0);
        for (int i = 1; i < 4; i++) chk("t2_spacing", 32'(g_cyc[i] - g_cyc[i-1]), 32'd8);
        chk("t2_r0", 32'(r_prod[0]), 32'd2);
        chk("t2_r1", 32'(r_prod[1]), 32'd225);
        chk("t2_r2", 32'(r_prod[2]), 32'd21);
        chk("t2_r2_id", 32'(r_id[2]), 32'd2);
        wait_resp(r);
        chk("t2_r3", 32'(resp_product), 32'd2);
        tick();

        // Backpressure with requester 1 waiting
        resp_ready = 1'b0;
        set_req(0, 3, 5); req_valid = 3'b001;
        wait_grant(got, t);
        chk("t3_grant0", 32'(got), 32'b001);
        set_req(1, 6, 7); req_valid = 3'b010;
        wait_resp(r);
        chk("t3_latency", 32'(r - t), 32'd7);
        for (int k = 0; k < 20; k++) begin
            chk("t3_hold_valid", 32'(resp_valid), 32'd1);
            chk("t3_hold_id", 32'(resp_id), 32'd0);
            chk("t3_hold_product", 32'(resp_product), 32'd15);
            chk("t3_hold_req_ready", 32'(req_ready), 32'd0);
            tick();
        end
        resp_ready = 1'b1;
        wait_grant(got, t);
        req_valid = '0;
        chk("t3_grant1", 32'(got), 32'b010);
        wait_resp(r);
        chk("t3_id1", 32'(resp_id), 32'd1);
        chk("t3_product1", 32'(resp_product), 32'd42);
        tick();

        // Reset in the middle of WAIT
        set_req(0, 9, 9); req_valid = 3'b001;
        wait_grant(got, t);
        req_valid = '0;
        chk("t4_start", 32'(mul_start), 32'd1);
        repeat (3) tick();
        reset = 1'b1;
        #1;
        chk("t4_busy", 32'(busy), 32'd0);
        chk("t4_resp_valid", 32'(resp_valid), 32'd0);
        chk("t4_resp_id", 32'(resp_id), 32'd0);
        chk("t4_resp_product", 32'(resp_product), 32'd0);
        chk("t4_operand_a", 32'(mul_multiplicand), 32'd0);
        chk("t4_operand_b", 32'(mul_multiplier), 32'd0);
        chk("t4_mul_start", 32'(mul_start), 32'd0);
        tick();
        reset = 1'b0;
        set_req(2, 12, 10); req_valid = 3'b100;
        wait_grant(got, t);
        req_valid = '0;
        chk("t4_grant2", 32'(got), 32'b100);
        wait_resp(r);
        chk("t4_latency", 32'(r - t), 32'd7);
        chk("t4_id", 32'(resp_id), 32'd2);
        chk("t4_product", 32'(resp_product), 32'd120);
        tick();

        // Pointer wraps to 0 after serving index 2
        set_req(0, 2, 3); set_req(2, 4, 4); req_valid = 3'b101;
        wait_grant(got, t);
        req_valid = 3'b100;
        chk("t5_first", 32'(got), 32'b001);
        wait_resp(r);
        chk("t5_product0", 32'(resp_product), 32'd6);
        tick();
        wait_grant(got, t);
        req_valid = '0;
        chk("t5_second", 32'(got), 32'b100);
        wait_resp(r);
        chk("t5_product2", 32'(resp_product), 32'd16);
        tick();

        // Zero operand
        set_req(0, 0, 9); req_valid = 3'b001;
        wait_grant(got, t);
        req_valid = '0;
`ifdef MULT_ARB_ZERO_BYPASS_EN
        chk("t6_no_start", 32'(mul_start), 32'd0);
        chk("t6_resp_valid", 32'(resp_valid), 32'd1);
        chk("t6_product", 32'(resp_product), 32'd0);
        tick();
        chk("t6_idle", 32'(busy), 32'd0);
        set_req(0, 5, 5); req_valid = 3'b001;
        wait_grant(got, t);
        req_valid = '0;
        chk("t6_start", 32'(mul_start), 32'd1);
        wait_resp(r);
        chk("t6_latency", 32'(r - t), 32'd7);
        chk("t6_product25", 32'(resp_product), 32'd25);
`else
        chk("t6_start", 32'(mul_start), 32'd1);
        wait_resp(r);
        chk("t6_latency", 32'(r - t), 32'd7);
        chk("t6_product", 32'(resp_product), 32'd0);
`endif
        repeat (3) tick();

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog cycle=%0d actual=running required=finished", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mult_share_arbiter.md
Name: mult_share_arbiter

Overview:
- Round-robin arbiter that shares one N-bit sequential shift-add multiplier between R requesters.
- The multiplier interface is start / ready / multiplicand / multiplier / 2N-bit product. The multiplier is idle with ready=1. Start is sampled while ready=1. Ready then stays low for exactly N cycles, and the product stays stable until the next start.
- This block accepts operand requests, serialises them onto the multiplier, and returns each product on one shared response channel tagged with the requester index.

Parameters:
- N, 4, operand width; must match the shared multiplier's N.
- R, 3, number of requesters, R >= 2.
- IDW, $clog2(R), width of resp_id.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  R  per-requester request valid
- req_ready  out  R  per-requester accept (one-hot or zero)
- req_a  in  R*N  multiplicands, requester i at [i*N +: N]
- req_b  in  R*N  multipliers, requester i at [i*N +: N]
- resp_valid  out  1  product available
- resp_ready  in  1  response consumer accept
- resp_id  out  IDW  index of the requester owning the response
- resp_product  out  2N  product
- mul_start  out  1  start pulse to multiplier
- mul_multiplicand  out  N  registered operand A
- mul_multiplier  out  N  registered operand B
- mul_ready  in  1  multiplier idle / product valid
- mul_product  in  2N  multiplier product
- busy  out  1  high in any state except IDLE

Behaviour:
- Reset is asynchronous, active-high. Clock is clock. It must share its reset with the multiplier.
- Reset values:
  - state = IDLE, rr_ptr = 0.
  - req_ready = 0, resp_valid = 0, resp_id = 0, resp_product = 0.
  - mul_start = 0, operand registers = 0, busy = 0.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req_valid and mul_ready=1, grant exactly one requester g: the first set bit searching rr_ptr, rr_ptr+1, … modulo R.
  - req_ready[g]=1 combinationally in the same cycle; all other bits are 0.
  - At the clock edge: capture req_a[g] and req_b[g] into the operand registers, capture g into the id register, set rr_ptr = (g+1) mod R, go to ISSUE.
  - If mul_ready=0, no grant is made.
- ISSUE: mul_start=1 for exactly one cycle; next state WAIT.
- WAIT:
  - mul_start=0.
  - When mul_ready=1, register mul_product into resp_product and go to RESP.
  - The first WAIT cycle always sees mul_ready=0, because the multiplier is evaluating.
- RESP:
  - resp_valid=1; resp_id and resp_product are held stable.
  - When resp_ready=1, go to IDLE (resp_valid deasserts next cycle).
  - Backpressure holds RESP indefinitely. No new request is accepted until the response is consumed.
- Latency: accept at cycle t (req_valid & req_ready) → mul_start at t+1 → resp_valid first high at t+N+3.
- Back-to-back throughput: with resp_ready tied high, a new grant occurs at most every N+4 cycles.
- Operand registers drive mul_multiplicand / mul_multiplier continuously. They change only on a grant.
- Requesters may drop req_valid before being granted; no state is kept for un-granted requests.
- Simultaneous requests: round-robin fairness. Any continuously-requesting requester is granted within R grants.
- rr_ptr wraps from R-1 to 0.
- Reset mid-operation (any state): all state returns to reset values. Any pending response is lost, and the multiplier is reset in the same cycle.
- Products are unsigned, full 2N bits, no truncation.

Optional Feature:
- Macro: MULT_ARB_ZERO_BYPASS_EN.
- Defined:
  - In IDLE, if the granted operands have req_a==0 or req_b==0, go directly IDLE→RESP with resp_product=0.
  - mul_start is not asserted, and resp_valid is high at t+1.
  - Round-robin update is unchanged.
- Undefined: every request goes through ISSUE/WAIT regardless of operand values.

Test Plan (all N=4, R=3, macro undefined unless stated):
- Single request: req_valid=3'b001, a=4'd13, b=4'd11, resp_ready=1 → req_ready=3'b001 at accept cycle t; one-cycle mul_start at t+1; resp_valid at t+7 with resp_id=0, resp_product=8'd143.
- All three request continuously: (1,2), (15,15), (7,3) at indices 0,1,2, resp_ready=1 → grants in order 0,1,2,0; products 2, 225, 21; grants spaced 8 cycles apart.
- Backpressure: resp_ready=0 for 20 cycles after resp_valid → resp_valid, resp_id, resp_product held stable; req_ready stays 0 for a waiting requester 1; grant to it occurs after resp_ready=1.
- Reset mid-WAIT: assert reset 3 cycles after mul_start → all outputs 0 immediately; rr_ptr=0; next request from index 2 alone is served correctly.
- Wrap: after a grant to index 2, requests on 0 and 2 simultaneously → index 0 granted first.
- MULT_ARB_ZERO_BYPASS_EN defined: a=0, b=9 → mul_start never asserted; resp_valid at t+1 with product 0. Then a=5, b=5 → normal path, product 25 at t+7.
